frame_buf_ctrl: RTL
===================

# frame_buf_ctrl

Ping-pong frame-buffer controller between the pixel producer (pattern/camera writer feeding the SDRAM write FIFO) and the LCD scan-out path (SDRAM read FIFO drained by the LCD driver). It owns two SDRAM frame regions and hands the producer a write base and the display a read base. It counts written pixels to detect frame completion. It swaps buffers only at an LCD frame start, so the display never shows a partially written frame.

## Interface
- FRAME_LEN, 384000, pixels per frame (800x480); legal range 2..2^20
- ADDR_W, 24, SDRAM address width
- BASE_A, 24'h000000, buffer A start address
- BASE_B, 24'h100000, buffer B start address

Ports:
- clk_50m  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sdram_init_done  in  1  SDRAM initialised; level
- lcd_vs  in  1  LCD vsync, lcd_pclk domain, active-low
- frame_req  in  1  producer requests a new frame write; 1-cycle pulse
- pix_wr  in  1  producer pixel strobe (same as FIFO wr_en)
- wr_base  out  ADDR_W  start address for the SDRAM write port
- wr_load  out  1  1-cycle pulse: SDRAM write port reloads address from wr_base
- rd_base  out  ADDR_W  start address for the SDRAM read port
- rd_load  out  1  1-cycle pulse: SDRAM read port reloads address from rd_base
- frame_busy  out  1  high in WRITE state
- frame_done  out  1  1-cycle pulse on the last pixel of a frame
- frame_drop  out  1  1-cycle pulse when frame_req is ignored
- ovf_err  out  1  sticky: pix_wr seen outside WRITE

## Operation
- wr_sel is a register; wr_base = wr_sel ? BASE_B : BASE_A; rd_base = wr_sel ? BASE_A : BASE_B. Both outputs are registered.
- lcd_vs is synchronised by two flops, then registered once more. vs_start = prev high and current low, i.e. a falling edge.
- pix_cnt is 20 bits and cleared on entry to WRITE.
- States:
  - WAIT_INIT: leave when sdram_init_done=1, going to READY.
  - READY: on frame_req, pulse wr_load next cycle, clear pix_cnt, go to WRITE.
  - WRITE: each pix_wr increments pix_cnt. A pix_wr with pix_cnt==FRAME_LEN-1 pulses frame_done and goes to PEND.
  - PEND: on vs_start, toggle wr_sel, pulse rd_load with the new rd_base, go to READY.
- rd_load also pulses on every vs_start in READY/WRITE, with rd_base unchanged. The display therefore re-reads the last complete buffer each frame. Never pulses in WAIT_INIT.
- frame_req in WAIT_INIT/WRITE/PEND pulses frame_drop and is otherwise ignored. No queuing.
- pix_wr in WAIT_INIT/READY/PEND sets ovf_err. It stays set until reset.
- sdram_init_done falling in any state forces WAIT_INIT on the next cycle:
  - wr_sel=0, pix_cnt=0
  - pulses suppressed
  - ovf_err kept

## Timing
- Reset values:
  - state=WAIT_INIT, wr_sel=0
  - wr_base=BASE_A, rd_base=BASE_B
  - wr_load, rd_load, frame_busy, frame_done, frame_drop = 0
  - ovf_err=0, sync flops=1
- frame_req sampled high in READY (cycle N): wr_load=1 and frame_busy=1 at N+1. pix_wr is counted from N+1 onward.
- Last pix_wr at cycle M: frame_done=1 and frame_busy=0 at M+1.
- lcd_vs falling edge sampled at clk edge K: vs_start is true at K+2, rd_load=1 at K+3.
  - For a swap, rd_base takes its new value at K+3, in the same cycle as rd_load.
- vs_start in the same cycle as the last pix_wr: no swap that frame. The swap happens at the next vs_start.
- frame_req in the same cycle as a PEND→READY transition: dropped, frame_drop=1 next cycle.
- All pulses are exactly one cycle wide.
- No combinational path from any input to any output.

## Test plan
- Reset, then hold sdram_init_done=0 and toggle lcd_vs:
  - wr_base=0x000000, rd_base=0x100000
  - no rd_load
  - after init_done=1, rd_load pulses 3 cycles after each lcd_vs fall.
- FRAME_LEN=16, frame_req, then 16 pix_wr:
  - wr_load 1 cycle after frame_req
  - frame_done after the 16th pix_wr
  - next vs_start: rd_base=0x000000 and wr_base=0x100000 at the rd_load cycle.
- Two full frames: buffers alternate A→B→A. The second frame's wr_load shows wr_base=0x100000.
- frame_req during WRITE and during PEND: frame_drop pulses each time, and pix_cnt is undisturbed.
- pix_wr in READY sets ovf_err=1. It stays 1 through a further full frame and clears only on rst_n.
- Mid-frame (pix_cnt=7), drop sdram_init_done:
  - state WAIT_INIT, wr_base=0x000000
  - on re-init, a frame_req starts a fresh count and frame_done comes after 16 pix_wr.

Source files
------------

// File: rtl/frame_buf_ctrl_if.sv
// rtl/frame_buf_ctrl_if.sv - producer/display handshake bundle for the ping-pong frame buffer
interface frame_buf_ctrl_if #(
    parameter int ADDR_W = 24
);
    logic              sdram_init_done;
    logic              lcd_vs;
    logic              frame_req;
    logic              pix_wr;
    logic [ADDR_W-1:0] wr_base;
    logic              wr_load;
    logic [ADDR_W-1:0] rd_base;
    logic              rd_load;
    logic              frame_busy;
    logic              frame_done;
    logic              frame_drop;
    logic              ovf_err;

    modport master (
        output sdram_init_done, lcd_vs, frame_req, pix_wr,
        input  wr_base, wr_load, rd_base, rd_load,
        input  frame_busy, frame_done, frame_drop, ovf_err
    );

    modport slave (
        input  sdram_init_done, lcd_vs, frame_req, pix_wr,
        output wr_base, wr_load, rd_base, rd_load,
        output frame_busy, frame_done, frame_drop, ovf_err
    );
endinterface

// File: rtl/frame_buf_ctrl.sv
// rtl/frame_buf_ctrl.sv - ping-pong SDRAM frame buffer controller, swaps only at LCD frame start
module frame_buf_ctrl #(
    parameter int unsigned       FRAME_LEN = 384000,
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] BASE_A    = ADDR_W'('h000000),
    parameter logic [ADDR_W-1:0] BASE_B    = ADDR_W'('h100000)
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    frame_buf_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        WAIT_INIT,
        READY,
        WRITE,
        PEND
    } state_t;

    localparam logic [19:0] LAST_PIX = 20'(FRAME_LEN - 1);

    state_t            state;
    logic              wr_sel;
    logic [19:0]       pix_cnt;
    logic              vs_s1, vs_s2, vs_s3;
    logic              vs_start;
    logic [ADDR_W-1:0] wr_base_q, rd_base_q;
    logic              wr_load_q, rd_load_q;
    logic              frame_busy_q, frame_done_q, frame_drop_q, ovf_err_q;

    // vs_s3 is the extra register behind the synchroniser; a high-to-low step is a frame start
    assign vs_start = vs_s3 & ~vs_s2;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_INIT;
            wr_sel       <= 1'b0;
            pix_cnt      <= '0;
            vs_s1        <= 1'b1;
            vs_s2        <= 1'b1;
            vs_s3        <= 1'b1;
            wr_base_q    <= BASE_A;
            rd_base_q    <= BASE_B;
            wr_load_q    <= 1'b0;
            rd_load_q    <= 1'b0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_drop_q <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            vs_s1        <= bus.lcd_vs;
            vs_s2        <= vs_s1;
            vs_s3        <= vs_s2;
            wr_load_q    <= 1'b0;
            rd_load_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_drop_q <= 1'b0;

            if (bus.pix_wr && state != WRITE)
                ovf_err_q <= 1'b1;

            // Losing SDRAM abandons everything except the sticky overflow flag
            if (!bus.sdram_init_done && state != WAIT_INIT) begin
                state        <= WAIT_INIT;
                wr_sel       <= 1'b0;
                pix_cnt      <= '0;
                wr_base_q    <= BASE_A;
                rd_base_q    <= BASE_B;
                frame_busy_q <= 1'b0;
            end else begin
                case (state)
                    WAIT_INIT: begin
                        if (bus.frame_req)
                            frame_drop_q <= 1'b1;
                        if (bus.sdram_init_done)
                            state <= READY;
                    end
                    READY: begin
                        if (vs_start)
                            rd_load_q <= 1'b1;
                        if (bus.frame_req) begin
                            wr_load_q    <= 1'b1;
                            frame_busy_q <= 1'b1;
                            pix_cnt      <= '0;
                            state        <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (bus.frame_req)
                            frame_drop_q <= 1'b1;
                        if (vs_start)
                            rd_load_q <= 1'b1;
                        if (bus.pix_wr) begin
                            pix_cnt <= pix_cnt + 20'd1;
                            if (pix_cnt == LAST_PIX) begin
                                frame_done_q <= 1'b1;
                                frame_busy_q <= 1'b0;
                                state        <= PEND;
                            end
                        end
                    end
                    PEND: begin
                        if (bus.frame_req)
                            frame_drop_q <= 1'b1;
                        // Bases follow the toggled select in the same edge as rd_load
                        if (vs_start) begin
                            wr_sel    <= ~wr_sel;
                            wr_base_q <= wr_sel ? BASE_A : BASE_B;
                            rd_base_q <= wr_sel ? BASE_B : BASE_A;
                            rd_load_q <= 1'b1;
                            state     <= READY;
                        end
                    end
                    default: state <= WAIT_INIT;
                endcase
            end
        end
    end

    assign bus.wr_base    = wr_base_q;
    assign bus.rd_base    = rd_base_q;
    assign bus.wr_load    = wr_load_q;
    assign bus.rd_load    = rd_load_q;
    assign bus.frame_busy = frame_busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_drop = frame_drop_q;
    assign bus.ovf_err    = ovf_err_q;
endmodule
